sdram_multi_port_arbiter: RTL and testbench
===========================================

SDRAM_MULTI_PORT_ARBITER -- requirements
Module: sdram_multi_port_arbiter

Interface
REQ-001 Parameter: NR_OF_MASTERS, default 4, number of bus masters sharing one SDRAM port; legal range 1..16.
REQ-002 Parameter: PRIORITY_MODE, default 0; 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-003 Parameter: TIMEOUT_CYCLES, default 1024, watchdog limit; legal values >= 2.
REQ-004 clock  in  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 requestIn  in  NR_OF_MASTERS  per-master bus request, level-sensitive.
REQ-007 grantOut  out  NR_OF_MASTERS  one-hot or all-zero grant, registered.
REQ-008 beginTransactionIn  in  1  shared-bus beginTransaction (OR of all masters).
REQ-009 endTransactionIn  in  1  shared-bus endTransaction (OR of masters and SDRAM controller).
REQ-010 busErrorIn  in  1  shared-bus busError.
REQ-011 endTransactionOut  out  1  arbiter-forced endTransaction, used by the watchdog only.
REQ-012 busErrorOut  out  1  arbiter-forced busError, used by the watchdog only.
REQ-013 activeMasterOut  out  max(1,$clog2(NR_OF_MASTERS))  index of the granted master; 0 when idle.
REQ-014 busIdleOut  out  1  high when the state is IDLE.

Function
REQ-015 The state machine SHALL have four states: IDLE, GRANTED, BUSY and ABORT.
REQ-016 In IDLE with any requestIn bit set at an edge, the block SHALL select a winner and enter GRANTED, with grantOut one-hot valid from the next cycle (1-cycle latency).
REQ-017 In round-robin mode, the search SHALL start at (lastGranted+1) mod NR_OF_MASTERS, wrapping past index NR_OF_MASTERS-1 to 0; lastGranted resets to NR_OF_MASTERS-1.
REQ-018 In fixed-priority mode, the lowest set index SHALL win and lastGranted SHALL be ignored.
REQ-019 In GRANTED, beginTransactionIn SHALL move the state to BUSY.
REQ-020 In GRANTED, if the granted master's request drops without beginTransactionIn, the state SHALL return to IDLE and grantOut SHALL clear the next cycle.
REQ-021 In BUSY, the grant SHALL be held regardless of requestIn.
REQ-022 In BUSY, endTransactionIn or busErrorIn SHALL move the state to IDLE and update lastGranted to the granted index.
REQ-023 Turnaround: with end sampled at edge t, grantOut SHALL be 0 during cycle t+1, and the earliest next grant SHALL be visible in cycle t+2.
REQ-024 If beginTransactionIn and endTransactionIn are sampled together in GRANTED, the transaction SHALL be treated as zero-length and the state SHALL go to IDLE.
REQ-025 grantOut SHALL never have more than one bit set.
REQ-026 Request changes in GRANTED or BUSY SHALL not alter the current grant.
REQ-027 For NR_OF_MASTERS = 1, the pointer logic SHALL be absent; behaviour otherwise follows REQ-015..026.

Reset
REQ-028 While resetN is low: state = IDLE, grantOut = 0, activeMasterOut = 0, busIdleOut = 1, endTransactionOut = 0, busErrorOut = 0, watchdog count = 0, lastGranted = NR_OF_MASTERS-1.
REQ-029 Reset asserted mid-transaction SHALL drop the grant immediately (asynchronously); no forced end is generated.
REQ-030 Reset deassertion is synchronous to clock; the first arbitration happens at the first edge after release.

Configuration
REQ-031 With macro SDRAM_ARBITER_WATCHDOG_EN defined, a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL count every cycle in GRANTED or BUSY and clear on every state change.
REQ-032 With the watchdog enabled, a count reaching TIMEOUT_CYCLES SHALL enter ABORT.
REQ-033 In ABORT, endTransactionOut and busErrorOut SHALL be 1 for exactly one cycle, grantOut SHALL be 0, and the state SHALL then go to IDLE with lastGranted updated.
REQ-034 Without the macro, no counter is present, ABORT is unreachable, and endTransactionOut and busErrorOut are tied to 0.

Structure
REQ-035 A shared package sdram_arbiter_pkg SHALL hold the state enum, the PRIORITY_MODE constants (PRIO_ROUND_ROBIN=0, PRIO_FIXED=1) and the maximum master count (16).
REQ-036 The winner search SHALL be a sub-module, sdram_arbiter_picker: a combinational one-hot picker taking the request vector, start index and mode.

Verification
REQ-037 N=4, round-robin, requestIn=4'b1111 held, each transaction begins the cycle after grant and lasts 3 cycles -> grants in order 0,1,2,3,0, with a 1-cycle grant gap between each.
REQ-038 N=4, fixed priority, requestIn=4'b1010 -> grant 1 repeatedly; master 3 never granted while bit 1 stays set.
REQ-039 Grant master 2, request drops in GRANTED with no begin -> grantOut=0 next cycle and busIdleOut=1.
REQ-040 Watchdog enabled, TIMEOUT_CYCLES=8, begin given but end withheld -> one-cycle endTransactionOut=busErrorOut=1 exactly 8 cycles after entering BUSY, then the next requester is granted.
REQ-041 resetN pulled low during BUSY with grantOut=4'b0100 -> grantOut=0 with no clock edge; after release with requestIn=4'b0001 -> grant 0 visible one cycle after the first edge.
REQ-042 begin and end in the same cycle in GRANTED with requestIn=4'b0011 held -> return to IDLE, and in round-robin mode the next grant goes to the other master.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM multi-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arbiter_pkg;

  localparam int MAX_MASTERS      = 16;
  localparam int PRIO_ROUND_ROBIN = 0;
  localparam int PRIO_FIXED       = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2,
    ST_ABORT   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_picker.sv
// One-hot winner search over a request vector, circular from a start index.
// Latency: purely combinational.
// Backpressure: none; valid_out low when no request bit is set.
//
// Ports:
//   req_in    - request vector, one bit per master
//   start_in  - first index examined in round-robin mode
//   mode_in   - 0 = round-robin from start_in, 1 = fixed priority (index 0 first)
//   grant_out - one-hot winner (all-zero when nothing requested)
//   index_out - binary index of the winner
//   valid_out - a winner exists
module sdram_arbiter_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_in,
  input  logic [IW-1:0] start_in,
  input  logic          mode_in,
  output logic [N-1:0]  grant_out,
  output logic [IW-1:0] index_out,
  output logic          valid_out
);

  int base;
  int idx;

  always_comb begin
    grant_out = '0;
    index_out = '0;
    valid_out = 1'b0;
    base      = mode_in ? 0 : int'(start_in);
    idx       = 0;
    // Walk all N positions once, wrapping past N-1 back to 0; the first
    // set bit encountered wins.
    for (int i = 0; i < N; i++) begin
      idx = base + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!valid_out && req_in[idx]) begin
        valid_out      = 1'b1;
        grant_out[idx] = 1'b1;
        index_out      = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_multi_port_arbiter.sv
// Grants one of NR_OF_MASTERS bus masters access to a shared SDRAM port.
// Latency: request sampled in IDLE -> registered one-hot grant next cycle;
//   1-cycle all-zero gap after every transaction end.
// Backpressure: masters hold requestIn until granted; grant is held through
//   BUSY until endTransactionIn/busErrorIn (or the watchdog) closes it.
//
// Optional feature: define SDRAM_ARBITER_WATCHDOG_EN to add a watchdog that
// forces a one-cycle endTransactionOut/busErrorOut (ABORT state) after
// TIMEOUT_CYCLES cycles in GRANTED or BUSY. Without it those outputs are 0.
//
// Ports:
//   clock, resetN       - rising-edge clock, async active-low reset
//   requestIn           - per-master level request
//   grantOut            - registered one-hot / all-zero grant
//   beginTransactionIn  - shared bus begin
//   endTransactionIn    - shared bus end
//   busErrorIn          - shared bus error
//   endTransactionOut   - watchdog-forced end
//   busErrorOut         - watchdog-forced error
//   activeMasterOut     - index of granted master, 0 when idle
//   busIdleOut          - state is IDLE
module sdram_multi_port_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS  = 4,
  parameter int PRIORITY_MODE  = PRIO_ROUND_ROBIN,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NR_OF_MASTERS-1:0] requestIn,
  output logic [NR_OF_MASTERS-1:0] grantOut,
  input  logic                     beginTransactionIn,
  input  logic                     endTransactionIn,
  input  logic                     busErrorIn,
  output logic                     endTransactionOut,
  output logic                     busErrorOut,
  output logic [$clog2(NR_OF_MASTERS > 1 ? NR_OF_MASTERS : 2)-1:0] activeMasterOut,
  output logic                     busIdleOut
);

  localparam int IW = $clog2(NR_OF_MASTERS > 1 ? NR_OF_MASTERS : 2);

  arb_state_t               state_q, state_d;
  logic [NR_OF_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]            active_q, active_d;
  logic                     ptr_upd;     // transaction closed: pointer takes active_q
  logic [IW-1:0]            start_idx;
  logic [NR_OF_MASTERS-1:0] pick_grant;
  logic [IW-1:0]            pick_idx;
  logic                     pick_vld;
  logic                     wd_expired;

  sdram_arbiter_picker #(
    .N  (NR_OF_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_in    (requestIn),
    .start_in  (start_idx),
    .mode_in   (PRIORITY_MODE == PRIO_FIXED),
    .grant_out (pick_grant),
    .index_out (pick_idx),
    .valid_out (pick_vld)
  );

  // Round-robin pointer: the last master that completed a transaction.
  // With a single master there is nothing to rotate.
  generate
    if (NR_OF_MASTERS > 1) begin : g_ptr
      logic [IW-1:0] last_q, last_d;

      always_comb begin
        last_d = ptr_upd ? active_q : last_q;
      end

      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          last_q <= IW'(NR_OF_MASTERS - 1);
        end else begin
          last_q <= last_d;
        end
      end

      assign start_idx = (last_q == IW'(NR_OF_MASTERS - 1)) ? '0 : last_q + IW'(1);
    end else begin : g_no_ptr
      assign start_idx = '0;
    end
  endgenerate

`ifdef SDRAM_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Count cycles spent in the current GRANTED/BUSY visit; any state change
  // restarts from zero.
  always_comb begin
    wd_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_GRANTED) || (state_q == ST_BUSY))) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES is the one that
  // enters ABORT, so ABORT is visible exactly TIMEOUT_CYCLES cycles after
  // entering GRANTED/BUSY.
  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      active_q <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    active_d = active_q;
    ptr_upd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d  = ST_GRANTED;
          grant_d  = pick_grant;
          active_d = pick_idx;
        end
      end
      ST_GRANTED: begin
        if (beginTransactionIn && endTransactionIn) begin
          // Zero-length transaction: counts as served for rotation.
          state_d  = ST_IDLE;
          grant_d  = '0;
          active_d = '0;
          ptr_upd  = 1'b1;
        end else if (beginTransactionIn) begin
          state_d = ST_BUSY;
        end else if (!requestIn[active_q]) begin
          // Master withdrew before starting; it was never served.
          state_d  = ST_IDLE;
          grant_d  = '0;
          active_d = '0;
        end else if (wd_expired) begin
          state_d = ST_ABORT;
          grant_d = '0;
        end
      end
      ST_BUSY: begin
        if (endTransactionIn || busErrorIn) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          active_d = '0;
          ptr_upd  = 1'b1;
        end else if (wd_expired) begin
          state_d = ST_ABORT;
          grant_d = '0;
        end
      end
      ST_ABORT: begin
        // active_q is kept through ABORT so the pointer can advance here.
        state_d  = ST_IDLE;
        grant_d  = '0;
        active_d = '0;
        ptr_upd  = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        active_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    grantOut        = grant_q;
    activeMasterOut = active_q;
    busIdleOut      = (state_q == ST_IDLE);
`ifdef SDRAM_ARBITER_WATCHDOG_EN
    endTransactionOut = (state_q == ST_ABORT);
    busErrorOut       = (state_q == ST_ABORT);
`else
    endTransactionOut = 1'b0;
    busErrorOut       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sdram_multi_port_arbiter.sv
module tb_sdram_multi_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;

  // Instance A: 4 masters, round-robin
  logic [3:0] req_a, gnt_a;
  logic       bgn_a, end_a, err_a, eto_a, beo_a, idle_a;
  logic [1:0] act_a;

  // Instance B: 4 masters, fixed priority, short watchdog limit
  logic [3:0] req_b, gnt_b;
  logic       bgn_b, end_b, err_b, eto_b, beo_b, idle_b;
  logic [1:0] act_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_multi_port_arbiter #(
    .NR_OF_MASTERS  (4),
    .PRIORITY_MODE  (0),
    .TIMEOUT_CYCLES (1024)
  ) dut_a (
    .clock              (clk),
    .resetN             (rst_n),
    .requestIn          (req_a),
    .grantOut           (gnt_a),
    .beginTransactionIn (bgn_a),
    .endTransactionIn   (end_a),
    .busErrorIn         (err_a),
    .endTransactionOut  (eto_a),
    .busErrorOut        (beo_a),
    .activeMasterOut    (act_a),
    .busIdleOut         (idle_a)
  );

  sdram_multi_port_arbiter #(
    .NR_OF_MASTERS  (4),
    .PRIORITY_MODE  (1),
    .TIMEOUT_CYCLES (8)
  ) dut_b (
    .clock              (clk),
    .resetN             (rst_n),
    .requestIn          (req_b),
    .grantOut           (gnt_b),
    .beginTransactionIn (bgn_b),
    .endTransactionIn   (end_b),
    .busErrorIn         (err_b),
    .endTransactionOut  (eto_b),
    .busErrorOut        (beo_b),
    .activeMasterOut    (act_b),
    .busIdleOut         (idle_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_a = '0; bgn_a = 0; end_a = 0; err_a = 0;
    req_b = '0; bgn_b = 0; end_b = 0; err_b = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    repeat (3) tick();
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_grant_a actual=%b expected=%b", gnt_a, 4'b0000); end
    checks++; if (act_a !== 2'd0) begin errors++; $display("FAIL reset_active_a actual=%0d expected=0", act_a); end
    checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL reset_idle_a actual=%b expected=1", idle_a); end
    checks++; if ({eto_a, beo_a} !== 2'b00) begin errors++; $display("FAIL reset_forced_a actual=%b expected=00", {eto_a, beo_a}); end
    checks++; if (gnt_b !== 4'b0000) begin errors++; $display("FAIL reset_grant_b actual=%b expected=%b", gnt_b, 4'b0000); end
    // First arbitration at the first edge after release; RR starts at 0.
    req_a = 4'b0010;
    rst_n = 1'b1;
    tick();
    checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL reset_first_grant actual=%b expected=%b", gnt_a, 4'b0010); end
  endtask

  task automatic test_round_robin;
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    apply_reset();
    req_a = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << exp_idx[k];
      checks++; if ({gnt_a, act_a} !== {exp_g, 2'(exp_idx[k])}) begin errors++; $display("FAIL rr_grant_%0d actual=%b/%0d expected=%b/%0d", k, gnt_a, act_a, exp_g, exp_idx[k]); end
      bgn_a = 1; tick(); bgn_a = 0;
      checks++; if ({gnt_a, idle_a} !== {exp_g, 1'b0}) begin errors++; $display("FAIL rr_busy_%0d actual=%b/%b expected=%b/0", k, gnt_a, idle_a, exp_g); end
      tick();
      end_a = 1; tick(); end_a = 0;
      checks++; if ({gnt_a, idle_a, act_a} !== 7'b0000_1_00) begin errors++; $display("FAIL rr_gap_%0d actual=%b/%b/%0d expected=0000/1/0", k, gnt_a, idle_a, act_a); end
      tick();
    end
  endtask

  task automatic test_request_drop;
    apply_reset();
    req_a = 4'b0100;
    tick();
    checks++; if ({gnt_a, act_a} !== {4'b0100, 2'd2}) begin errors++; $display("FAIL drop_grant actual=%b/%0d expected=0100/2", gnt_a, act_a); end
    req_a = 4'b0000;
    tick();
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL drop_grant_clear actual=%b expected=0000", gnt_a); end
    checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL drop_idle actual=%b expected=1", idle_a); end
  endtask

  task automatic test_reset_mid_busy;
    apply_reset();
    req_a = 4'b0100;
    tick();
    bgn_a = 1; tick(); bgn_a = 0;
    req_a = 4'b1011;   // request change while BUSY must not move the grant
    tick();
    checks++; if ({gnt_a, idle_a} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL busy_hold actual=%b/%b expected=0100/0", gnt_a, idle_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL async_reset_grant actual=%b expected=0000", gnt_a); end
    checks++; if ({idle_a, eto_a, beo_a} !== 3'b100) begin errors++; $display("FAIL async_reset_flags actual=%b expected=100", {idle_a, eto_a, beo_a}); end
    req_a = 4'b0001;
    #1 rst_n = 1'b1;
    tick();
    checks++; if ({gnt_a, act_a} !== {4'b0001, 2'd0}) begin errors++; $display("FAIL post_reset_grant actual=%b/%0d expected=0001/0", gnt_a, act_a); end
  endtask

  task automatic test_zero_length;
    apply_reset();
    req_a = 4'b0011;
    tick();
    checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL zl_first actual=%b expected=0001", gnt_a); end
    bgn_a = 1; end_a = 1; tick(); bgn_a = 0; end_a = 0;
    checks++; if ({gnt_a, idle_a} !== 5'b0000_1) begin errors++; $display("FAIL zl_idle actual=%b/%b expected=0000/1", gnt_a, idle_a); end
    tick();
    checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL zl_next actual=%b expected=0010", gnt_a); end
  endtask

  task automatic test_fixed_priority;
    apply_reset();
    req_b = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({gnt_b, act_b} !== {4'b0010, 2'd1}) begin errors++; $display("FAIL fixed_grant_%0d actual=%b/%0d expected=0010/1", k, gnt_b, act_b); end
      bgn_b = 1; tick(); bgn_b = 0;
      end_b = 1; tick(); end_b = 0;
      checks++; if (gnt_b !== 4'b0000) begin errors++; $display("FAIL fixed_gap_%0d actual=%b expected=0000", k, gnt_b); end
    end
  endtask

  task automatic test_watchdog;
    apply_reset();
    req_b = 4'b0110;
    tick();
    checks++; if (gnt_b !== 4'b0010) begin errors++; $display("FAIL wd_grant actual=%b expected=0010", gnt_b); end
    bgn_b = 1; tick(); bgn_b = 0;   // BUSY from here
    req_b = 4'b0100;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if ({eto_b, beo_b, gnt_b} !== 6'b00_0010) begin errors++; $display("FAIL wd_hold_%0d actual=%b expected=000010", k, {eto_b, beo_b, gnt_b}); end
    end
    tick();
`ifdef SDRAM_ARBITER_WATCHDOG_EN
    checks++; if ({eto_b, beo_b, gnt_b} !== 6'b11_0000) begin errors++; $display("FAIL wd_abort actual=%b expected=110000", {eto_b, beo_b, gnt_b}); end
    tick();
    checks++; if ({eto_b, beo_b, gnt_b, idle_b} !== 7'b00_0000_1) begin errors++; $display("FAIL wd_after actual=%b expected=0000001", {eto_b, beo_b, gnt_b, idle_b}); end
    tick();
    checks++; if (gnt_b !== 4'b0100) begin errors++; $display("FAIL wd_next actual=%b expected=0100", gnt_b); end
`else
    checks++; if ({eto_b, beo_b, gnt_b} !== 6'b00_0010) begin errors++; $display("FAIL wd_off_hold actual=%b expected=000010", {eto_b, beo_b, gnt_b}); end
    end_b = 1; tick(); end_b = 0;
    checks++; if ({eto_b, beo_b, gnt_b, idle_b} !== 7'b00_0000_1) begin errors++; $display("FAIL wd_off_end actual=%b expected=0000001", {eto_b, beo_b, gnt_b, idle_b}); end
    tick();
    checks++; if (gnt_b !== 4'b0100) begin errors++; $display("FAIL wd_off_next actual=%b expected=0100", gnt_b); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_request_drop();
    test_reset_mid_busy();
    test_zero_length();
    test_fixed_priority();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
